// File: rtl/crc8_pkg.sv
// Shared types, constants and the single-bit CRC-8 step used by the frame controller.
package crc8_pkg;

  localparam int unsigned CRC8_W   = 8;
  localparam int unsigned BITCNT_W = 3;

  localparam logic [CRC8_W-1:0] CRC8_POLY_DEFAULT = 8'h07;
  localparam logic [CRC8_W-1:0] CRC8_INIT_DEFAULT = 8'h00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // One MSB-first LFSR step; x^8 term of the polynomial is implicit.
  function automatic logic [CRC8_W-1:0] crc8_step(input logic [CRC8_W-1:0] crc,
                                                  input logic              in_bit,
                                                  input logic [CRC8_W-1:0] poly);
    logic fb;
    fb = crc[CRC8_W-1] ^ in_bit;
    return {crc[CRC8_W-2:0], 1'b0} ^ (fb ? poly : CRC8_W'(0));
  endfunction

endpackage

// File: rtl/crc8_lfsr.sv
// Bit-serial CRC-8 LFSR: clr reloads INIT and takes priority over shift.
module crc8_lfsr
  import crc8_pkg::*;
#(
  parameter logic [CRC8_W-1:0] POLY = CRC8_POLY_DEFAULT,
  parameter logic [CRC8_W-1:0] INIT = CRC8_INIT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              shift,
  input  logic              clr,
  input  logic              in,
  output logic [CRC8_W-1:0] crc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc <= INIT;
    end else if (clr) begin
      crc <= INIT;
    end else if (shift) begin
      crc <= crc8_step(crc, in, POLY);
    end
  end

endmodule

// File: rtl/crc8_frame_ctrl.sv
// Frame sequencer: accepts bytes over valid/ready, feeds them MSB-first into the
// LFSR one bit per clock, and publishes the frame CRC with a residue-zero flag.
module crc8_frame_ctrl
  import crc8_pkg::*;
#(
  parameter logic [CRC8_W-1:0] POLY = CRC8_POLY_DEFAULT,
  parameter logic [CRC8_W-1:0] INIT = CRC8_INIT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  input  logic [CRC8_W-1:0] s_data,
  input  logic              s_last,
  output logic              s_ready,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [CRC8_W-1:0] crc_out,
  output logic              crc_ok
);

  state_e              state_q;
  logic [BITCNT_W-1:0] bitcnt_q;
  logic [CRC8_W-1:0]   byte_q;
  logic                last_q;
  logic                hold_q;
  logic                rdy_q;

  logic                accept_c;
  logic                shift_c;
  logic                clr_c;
  logic                bit_c;
  logic [CRC8_W-1:0]   lfsr_crc;
  logic [CRC8_W-1:0]   crc_next;

  // Registered ready is gated by abort; crc_next lets the result publish on the last shift edge.
  always_comb begin
    s_ready  = rdy_q && !abort;
    accept_c = s_valid && s_ready;
    shift_c  = (state_q == SHIFT) && !hold_q && !abort;
    clr_c    = abort || ((state_q == IDLE) && accept_c);
    bit_c    = byte_q[~bitcnt_q];
    crc_next = crc8_step(lfsr_crc, bit_c, POLY);
  end

  crc8_lfsr #(
    .POLY(POLY),
    .INIT(INIT)
  ) u_lfsr (
    .clk  (clk),
    .rst_n(rst_n),
    .shift(shift_c),
    .clr  (clr_c),
    .in   (bit_c),
    .crc  (lfsr_crc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      bitcnt_q <= '0;
      byte_q   <= '0;
      last_q   <= 1'b0;
      hold_q   <= 1'b0;
      rdy_q    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      crc_out  <= '0;
      crc_ok   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state_q  <= IDLE;
        bitcnt_q <= '0;
        hold_q   <= 1'b0;
        rdy_q    <= 1'b1;
        busy     <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            rdy_q <= 1'b1;
            if (accept_c) begin
              byte_q   <= s_data;
              last_q   <= s_last;
              bitcnt_q <= '0;
              hold_q   <= 1'b0;
              rdy_q    <= 1'b0;
              busy     <= 1'b1;
              state_q  <= SHIFT;
            end
          end
          SHIFT: begin
            if (hold_q) begin
              // Stalled after a complete byte: LFSR frozen until the next byte lands.
              if (accept_c) begin
                byte_q   <= s_data;
                last_q   <= s_last;
                bitcnt_q <= '0;
                hold_q   <= 1'b0;
                rdy_q    <= 1'b0;
              end
            end else if (bitcnt_q == '1) begin
              if (last_q) begin
                state_q  <= DONE;
                bitcnt_q <= '0;
                busy     <= 1'b0;
                rdy_q    <= 1'b0;
                done     <= 1'b1;
                crc_out  <= crc_next;
                crc_ok   <= (crc_next == '0);
              end else if (accept_c) begin
                byte_q   <= s_data;
                last_q   <= s_last;
                bitcnt_q <= '0;
                rdy_q    <= 1'b0;
              end else begin
                hold_q <= 1'b1;
              end
            end else begin
              bitcnt_q <= bitcnt_q + BITCNT_W'(1);
              rdy_q    <= (bitcnt_q == BITCNT_W'(6)) && !last_q;
            end
          end
          DONE: begin
            state_q <= IDLE;
            rdy_q   <= 1'b1;
          end
          default: begin
            state_q <= IDLE;
            rdy_q   <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_crc8_frame_ctrl.sv
// Self-checking bench for crc8_frame_ctrl: cycle-count reference model plus directed and random frames.
module tb_crc8_frame_ctrl;

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b0;
  logic       s_valid = 1'b0;
  logic [7:0] s_data  = 8'h00;
  logic       s_last  = 1'b0;
  logic       abort   = 1'b0;
  logic       s_ready;
  logic       busy;
  logic       done;
  logic [7:0] crc_out;
  logic       crc_ok;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  crc8_frame_ctrl dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .s_valid(s_valid),
    .s_data (s_data),
    .s_last (s_last),
    .s_ready(s_ready),
    .abort  (abort),
    .busy   (busy),
    .done   (done),
    .crc_out(crc_out),
    .crc_ok (crc_ok)
  );

  // Reference model: edge counter n, expected ready window, expected done edge.
  int         n          = 0;
  int         ready_from = 1;
  int         done_at    = -1;
  int         last_edge  = 0;
  int         first_edge = 0;
  int         done_n     = 0;
  bit         active     = 1'b0;
  bit         m_acc      = 1'b0;
  bit         exp_done   = 1'b0;
  bit         exp_ok     = 1'b0;
  logic [7:0] m_crc      = 8'h00;
  logic [7:0] exp_crc    = 8'h00;
  logic [7:0] fb[$];

  // Byte-at-a-time CRC-8 (poly 0x07, init 0x00, no reflection).
  function automatic logic [7:0] crc_byte(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int i = 0; i < 8; i++) r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    return r;
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      n = 0; ready_from = 1; done_at = -1; active = 1'b0; m_acc = 1'b0;
      exp_done = 1'b0; exp_crc = 8'h00; exp_ok = 1'b0;
    end else begin
      m_acc = s_valid && (n >= ready_from) && !abort;
      n++;
      exp_done = 1'b0;
      if (abort) begin
        active = 1'b0; done_at = -1; ready_from = n;
      end else begin
        if (n == done_at) begin
          exp_done = 1'b1; exp_crc = m_crc; exp_ok = (m_crc == 8'h00);
          active = 1'b0; done_at = -1;
        end
        if (m_acc) begin
          if (!active) begin m_crc = 8'h00; first_edge = n; end
          active = 1'b1;
          m_crc  = crc_byte(m_crc, s_data);
          if (s_last) begin done_at = n + 8; ready_from = n + 9; last_edge = n; end
          else ready_from = n + 7;
        end
      end
    end
  end

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    chk1("s_ready", s_ready, (n >= ready_from) && !abort);
    chk1("busy", busy, active);
    chk1("done", done, exp_done);
    chk8("crc_out", crc_out, exp_crc);
    chk1("crc_ok", crc_ok, exp_ok);
  end

  task automatic idle(input int k);
    repeat (k) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l);
    bit got;
    got = 1'b0;
    s_valid = 1'b1; s_data = d; s_last = l;
    for (int i = 0; i < 64 && !got; i++) begin @(posedge clk); #1; got = m_acc; end
    s_valid = 1'b0; s_last = 1'b0;
    chk1("accept", got, 1'b1);
  endtask

  task automatic send_frame(input int gap_idx, input int gap_len);
    for (int i = 0; i < fb.size(); i++) begin
      if (i == gap_idx) idle(gap_len);
      send_byte(fb[i], i == fb.size() - 1);
    end
  endtask

  task automatic wait_done(input bit lit, input logic [7:0] ec, input logic eo, input string nm);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 24 && !seen; i++) begin @(negedge clk); seen = (done === 1'b1); end
    done_n = n;
    chk1({nm, "_done"}, seen, 1'b1);
    if (seen) begin
      chki({nm, "_lat"}, n - last_edge, 8);
      if (lit) begin
        chk8({nm, "_crc"}, crc_out, ec);
        chk1({nm, "_ok"}, crc_ok, eo);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
  endtask

  initial begin
    int len;
    int ab;
    repeat (2) @(negedge clk);
    chk1("rst_ready", s_ready, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk8("rst_crc", crc_out, 8'h00);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk1("idle_ready", s_ready, 1'b1);

    fb = {8'h01};
    send_frame(-1, 0); wait_done(1'b1, 8'h07, 1'b0, "b01");
    fb = {8'hFF};
    send_frame(-1, 0); wait_done(1'b1, 8'hF3, 1'b0, "bFF");
    fb = {8'h00};
    send_frame(-1, 0); wait_done(1'b1, 8'h00, 1'b1, "b00");

    fb = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    send_frame(-1, 0); wait_done(1'b1, 8'hF4, 1'b0, "b2b");
    chki("b2b_span", done_n - first_edge, 72);

    fb = {8'h01, 8'h07};
    send_frame(-1, 0); wait_done(1'b1, 8'h00, 1'b1, "chk_good");
    fb = {8'h01, 8'h06};
    send_frame(-1, 0); wait_done(1'b1, 8'h07, 1'b0, "chk_bad");

    // Long gap before byte 3 forces a stall with ready held high.
    fb = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    send_frame(2, 12); wait_done(1'b1, 8'hF4, 1'b0, "gap");

    send_byte(8'hAA, 1'b0);
    send_byte(8'h55, 1'b0);
    idle(3);
    pulse_abort();
    chk1("abort_busy", busy, 1'b0);
    idle(15);
    chk8("abort_keep", crc_out, 8'hF4);
    fb = {8'h01};
    send_frame(-1, 0); wait_done(1'b1, 8'h07, 1'b0, "post_abort");

    send_byte(8'hC3, 1'b0);
    idle(3);
    #2 rst_n = 1'b0;
    #1;
    chk1("arst_ready", s_ready, 1'b0);
    chk1("arst_busy", busy, 1'b0);
    chk1("arst_done", done, 1'b0);
    chk8("arst_crc", crc_out, 8'h00);
    chk1("arst_ok", crc_ok, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int f = 0; f < 40; f++) begin
      len = int'($urandom_range(1, 5));
      ab  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, len - 1)) : -1;
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 10)));
        send_byte(8'($urandom), i == len - 1);
        if (i == ab) begin
          idle(int'($urandom_range(0, 9)));
          pulse_abort();
          break;
        end
      end
      if (ab < 0) wait_done(1'b0, 8'h00, 1'b0, "rnd");
      else idle(2);
    end

    idle(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
